// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of a dual-clock FIFO: binary/gray write pointers, a two-flop
// synchroniser for the read pointer, and full / almost-full / level / overflow flags.
module async_fifo_wr_ctrl #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned AFULL_TH   = DEPTH - 4
) (
    input  logic                  wclk,
    input  logic                  wrstn,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    input  logic                  ovf_clr,
    output logic                  wenc,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rsync1_q, rsync2_q;
    logic [PW-1:0] rbin_s;
    logic          ovf_q, ovf_d;

    // Full when the write pointer is exactly one lap ahead: top two gray bits inverted.
    assign wfull = (wgray_q == {~rsync2_q[ADDR_WIDTH:ADDR_WIDTH-1], rsync2_q[ADDR_WIDTH-2:0]});
    assign wenc  = winc & ~wfull;

    always_comb begin
        wbin_d  = wbin_q + PW'(wenc);
        wgray_d = wbin_d ^ (wbin_d >> 1);
    end

    always_comb begin
        rbin_s = '0;
        for (int i = 0; i < int'(PW); i++) begin
            rbin_s[i] = ^(rsync2_q >> i);
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (winc && wfull) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            rsync1_q <= '0;
            rsync2_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            rsync1_q <= rptr_gray;
            rsync2_q <= rsync1_q;
            ovf_q    <= ovf_d;
        end
    end

    assign waddr        = wbin_q[ADDR_WIDTH-1:0];
    assign wptr_gray    = wgray_q;
    assign wlevel       = wbin_q - rbin_s;
    assign walmost_full = (wlevel >= PW'(AFULL_TH));
    assign woverflow    = ovf_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Bench for async_fifo_wr_ctrl: count-based occupancy model plus a write-address scoreboard.
module tb_async_fifo_wr_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned ATH   = 12;

    logic          wclk = 1'b0;
    logic          wrstn;
    logic          winc;
    logic [AW:0]   rptr_gray;
    logic          ovf_clr;
    logic          wenc;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr_gray;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wlevel;
    logic          woverflow;

    async_fifo_wr_ctrl #(
        .DEPTH    (DEPTH),
        .AFULL_TH (ATH)
    ) dut (
        .wclk         (wclk),
        .wrstn        (wrstn),
        .winc         (winc),
        .rptr_gray    (rptr_gray),
        .ovf_clr      (ovf_clr),
        .wenc         (wenc),
        .waddr        (waddr),
        .wptr_gray    (wptr_gray),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: total accepted writes, read count driven by the bench, and its 2-flop delayed copies.
    int m_w   = 0;
    int r_bin = 0;
    int m_r1  = 0;
    int m_r2  = 0;
    bit m_ovf = 1'b0;
    int n_wenc = 0;

    logic [AW-1:0] sb_q[$];

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int gray5(input int b);
        int v;
        v = b & 31;
        return v ^ (v >> 1);
    endfunction

    // One wclk cycle: drive inputs, check outputs against the model, then advance past the edge.
    task automatic cycle(input bit inc, input bit clr);
        int  lvl;
        bit  full;
        bit  acc;
        logic [AW-1:0] exp_a;
        winc      = inc;
        ovf_clr   = clr;
        rptr_gray = 5'(gray5(r_bin));
        #1;
        lvl  = m_w - m_r2;
        full = (lvl == int'(DEPTH));
        acc  = inc && !full;
        chk("wlevel", int'(wlevel), lvl);
        chk("wfull", int'(wfull), int'(full));
        chk("walmost_full", int'(walmost_full), int'(lvl >= int'(ATH)));
        chk("woverflow", int'(woverflow), int'(m_ovf));
        chk("wptr_gray", int'(wptr_gray), gray5(m_w));
        chk("wenc", int'(wenc), int'(acc));
        if (acc) sb_q.push_back(4'(m_w & 15));
        if (wenc) begin
            chk("sb_nonempty", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                exp_a = sb_q.pop_front();
                chk("waddr", int'(waddr), int'(exp_a));
            end
            n_wenc++;
        end
        if (acc) m_w++;
        if (inc && full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_r2 = m_r1;
        m_r1 = r_bin;
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wfull"}, int'(wfull), 0);
        chk({tag, "_wlevel"}, int'(wlevel), 0);
        chk({tag, "_wptr_gray"}, int'(wptr_gray), 0);
        chk({tag, "_woverflow"}, int'(woverflow), 0);
        chk({tag, "_walmost_full"}, int'(walmost_full), 0);
        chk({tag, "_waddr"}, int'(waddr), 0);
        chk({tag, "_wenc"}, int'(wenc), 0);
    endtask

    task automatic model_reset();
        m_w   = 0;
        r_bin = 0;
        m_r1  = 0;
        m_r2  = 0;
        m_ovf = 1'b0;
    endtask

    task automatic drain_all();
        r_bin = m_w;
        repeat (3) cycle(1'b0, 1'b0);
    endtask

    initial begin
        int w_d1;
        int w_d2;
        wrstn     = 1'b0;
        winc      = 1'b0;
        ovf_clr   = 1'b0;
        rptr_gray = '0;
        #2;
        chk_reset_vals("rst_in");
        @(posedge wclk);
        @(posedge wclk);
        #1;
        wrstn = 1'b1;
        repeat (2) cycle(1'b0, 1'b0);
        chk_reset_vals("rst_idle");

        // Fill against a stalled reader.
        n_wenc = 0;
        repeat (20) cycle(1'b1, 1'b0);
        chk("fill_wenc_count", n_wenc, 16);
        chk("fill_full", int'(wfull), 1);
        chk("fill_level", int'(wlevel), 16);
        chk("fill_gray", int'(wptr_gray), 5'b11000);
        chk("fill_ovf", int'(woverflow), 1);

        // Coincident set and clear: set wins; clear alone then takes effect.
        cycle(1'b1, 1'b1);
        chk("ovf_set_wins", int'(woverflow), 1);
        cycle(1'b0, 1'b1);
        chk("ovf_cleared", int'(woverflow), 0);
        cycle(1'b0, 1'b0);

        // One read becomes visible two edges later.
        r_bin = 1;
        cycle(1'b0, 1'b0);
        chk("drain_e1_full", int'(wfull), 1);
        cycle(1'b0, 1'b0);
        chk("drain_e2_full", int'(wfull), 0);
        chk("drain_e2_level", int'(wlevel), 15);
        n_wenc = 0;
        cycle(1'b1, 1'b0);
        chk("drain_one_write", n_wenc, 1);
        chk("drain_refull", int'(wfull), 1);

        // Stream across the pointer wrap with a reader lagging two cycles.
        drain_all();
        w_d1 = m_w;
        w_d2 = m_w;
        for (int i = 0; i < 40; i++) begin
            r_bin = w_d2;
            w_d2  = w_d1;
            w_d1  = m_w;
            cycle(1'b1, 1'b0);
            chk("wrap_level_le4", int'(wlevel <= 5'd4), 1);
            chk("wrap_not_full", int'(wfull), 0);
        end

        // Reset in the middle of a stream at level 9.
        drain_all();
        repeat (9) cycle(1'b1, 1'b0);
        chk("pre_rst_level", int'(wlevel), 9);
        #2;
        wrstn = 1'b0;
        winc  = 1'b0;
        model_reset();
        rptr_gray = '0;
        #1;
        chk_reset_vals("mid_rst");
        @(posedge wclk);
        #1;
        chk_reset_vals("mid_rst_edge");
        wrstn = 1'b1;
        repeat (3) cycle(1'b0, 1'b0);
        chk_reset_vals("post_rst");

        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
